board_history: RTL and testbench

Row-history store that sits directly downstream of the touch/scoring stage. It captures each completed guess row (four colour values plus white/black peg counts) at the moment the scoring stage advances to the next row, and keeps all eight rows for the LCD board renderer. It serves a registered random-read port to that renderer and flags game win/loss.

---
 rtl/board_history_pkg.sv | 36 +++
 rtl/board_history_if.sv | 39 +++
 rtl/board_row_ram.sv | 50 +++++
 rtl/board_history.sv | 156 +++++++++++++++
 tb/tb_board_history.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/board_history_pkg.sv
// Shared definitions for the board history store and the LCD renderer:
// geometry, field widths and the layout of one stored guess row.
package board_history_pkg;

    localparam int NUM_ROWS    = 8;
    localparam int ROW_IDX_W   = 3;
    localparam int COLOR_W     = 3;
    localparam int PEG_W       = 3;
    localparam int WIN_PEGS    = 4;
    localparam int ROWS_DONE_W = 4;

    // Stored row layout: colours in 11:0 (Value01 lowest), white 14:12, black 17:15.
    localparam int ENTRY_W   = 18;
    localparam int COLOR_LSB = 0;
    localparam int WHITE_LSB = 12;
    localparam int BLACK_LSB = 15;

    typedef logic [ROW_IDX_W-1:0] row_idx_t;
    typedef logic [ENTRY_W-1:0]   entry_t;

    function automatic entry_t pack_entry(
        input logic [COLOR_W-1:0] v1,
        input logic [COLOR_W-1:0] v2,
        input logic [COLOR_W-1:0] v3,
        input logic [COLOR_W-1:0] v4,
        input logic [PEG_W-1:0]   white,
        input logic [PEG_W-1:0]   black
    );
        return {black, white, v4, v3, v2, v1};
    endfunction

    function automatic logic [PEG_W-1:0] entry_black(input entry_t e);
        return e[BLACK_LSB +: PEG_W];
    endfunction

endpackage

// File: rtl/board_history_if.sv
// Bundle between the scoring stage / renderer side and the board history
// store. The master side drives live row data and the read address; the
// slave side (board_history) returns the stored row and the game flags.
interface board_history_if;
    import board_history_pkg::*;

    logic [ROW_IDX_W-1:0]   nrOfRows;
    logic [COLOR_W-1:0]     Value01;
    logic [COLOR_W-1:0]     Value02;
    logic [COLOR_W-1:0]     Value03;
    logic [COLOR_W-1:0]     Value04;
    logic [PEG_W-1:0]       WhitePegs;
    logic [PEG_W-1:0]       BlackPegs;
    logic [ROW_IDX_W-1:0]   rd_row;
    logic [COLOR_W-1:0]     rd_value01;
    logic [COLOR_W-1:0]     rd_value02;
    logic [COLOR_W-1:0]     rd_value03;
    logic [COLOR_W-1:0]     rd_value04;
    logic [PEG_W-1:0]       rd_white;
    logic [PEG_W-1:0]       rd_black;
    logic                   rd_valid;
    logic                   rd_active;
    logic [ROWS_DONE_W-1:0] rows_done;
    logic                   game_won;
    logic                   game_lost;

    modport master (
        output nrOfRows, Value01, Value02, Value03, Value04, WhitePegs, BlackPegs, rd_row,
        input  rd_value01, rd_value02, rd_value03, rd_value04, rd_white, rd_black,
        input  rd_valid, rd_active, rows_done, game_won, game_lost
    );

    modport slave (
        input  nrOfRows, Value01, Value02, Value03, Value04, WhitePegs, BlackPegs, rd_row,
        output rd_value01, rd_value02, rd_value03, rd_value04, rd_white, rd_black,
        output rd_valid, rd_active, rows_done, game_won, game_lost
    );

endinterface

// File: rtl/board_row_ram.sv
// 8 x 18 register file holding the captured guess rows. One write port and
// one registered read port; a read of the address written on the same edge
// returns the new data.
module board_row_ram
    import board_history_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic [ROW_IDX_W-1:0] waddr_i,
    input  logic [ENTRY_W-1:0]   wdata_i,
    input  logic [ROW_IDX_W-1:0] raddr_i,
    output logic [ENTRY_W-1:0]   rdata_o
);

    entry_t mem_q [NUM_ROWS];
    entry_t rdata_q;
    entry_t rdata_d;

    // Write-first read: forward the incoming write when addresses collide.
    always_comb begin
        rdata_d = mem_q[raddr_i];
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_d = wdata_i;
        end
    end

    // Row storage, cleared on reset so an unwritten slot reads as zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_ROWS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/board_history.sv
// Guess-row history for the board renderer. Shadows the live row every
// cycle; when the scoring stage moves to another row the shadow of the row
// just left is committed to its slot one cycle later. Tracks how many rows
// were played and freezes after a win or after the last row is played.
module board_history
    import board_history_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    board_history_if.slave bus
);

    row_idx_t               prev_row_q;
    entry_t                 prev_entry_q;
    entry_t                 live_entry;

    logic                   pend_q;
    row_idx_t               pend_row_q;
    entry_t                 pend_entry_q;

    logic [NUM_ROWS-1:0]    valid_q;
    logic [NUM_ROWS-1:0]    valid_d;
    logic [ROWS_DONE_W-1:0] rows_done_q;
    logic [ROWS_DONE_W-1:0] rows_done_d;
    logic                   won_q;
    logic                   won_d;
    logic                   lost_q;
    logic                   lost_d;

    logic                   rd_active_q;
    logic                   rd_active_d;
    logic                   rd_valid_q;
    logic                   rd_valid_d;

    logic                   pend_wins;
    logic                   pend_ends;
    logic                   frozen;
    logic                   capture;

    entry_t                 ram_rdata;
    entry_t                 rd_entry;

    assign live_entry = pack_entry(bus.Value01, bus.Value02, bus.Value03, bus.Value04,
                                   bus.WhitePegs, bus.BlackPegs);

    // Capture detection, end-of-game evaluation and next-state of the history control.
    always_comb begin
        pend_wins   = 1'b0;
        pend_ends   = 1'b0;
        frozen      = 1'b0;
        capture     = 1'b0;
        valid_d     = valid_q;
        rows_done_d = rows_done_q;
        won_d       = won_q;
        lost_d      = lost_q;
        rd_active_d = 1'b0;
        rd_valid_d  = 1'b0;

        pend_wins = (entry_black(pend_entry_q) == PEG_W'(WIN_PEGS));
        pend_ends = pend_wins || (pend_row_q == '0);
        // A capture about to end the game already blocks further captures.
        frozen    = won_q || lost_q || (pend_q && pend_ends);
        capture   = (bus.nrOfRows != prev_row_q) && !frozen;

        if (pend_q) begin
            valid_d[pend_row_q] = 1'b1;
            if (rows_done_q != ROWS_DONE_W'(NUM_ROWS)) begin
                rows_done_d = rows_done_q + ROWS_DONE_W'(1);
            end
            if (pend_wins) begin
                won_d = 1'b1;
            end else if (pend_row_q == '0) begin
                lost_d = 1'b1;
            end
        end

        rd_active_d = (bus.rd_row == bus.nrOfRows) && !frozen;
        rd_valid_d  = rd_active_d ? 1'b0 : valid_d[bus.rd_row];
    end

    // Shadow of the live row; starts at row 7 so the first active row is not captured.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_row_q   <= row_idx_t'(NUM_ROWS - 1);
            prev_entry_q <= '0;
        end else begin
            prev_row_q   <= bus.nrOfRows;
            prev_entry_q <= live_entry;
        end
    end

    // Pending write: the shadowed row waits one cycle before committing.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_q       <= 1'b0;
            pend_row_q   <= '0;
            pend_entry_q <= '0;
        end else begin
            pend_q       <= capture;
            pend_row_q   <= prev_row_q;
            pend_entry_q <= prev_entry_q;
        end
    end

    // Valid bits, played-row count and sticky end flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q     <= '0;
            rows_done_q <= '0;
            won_q       <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rows_done_q <= rows_done_d;
            won_q       <= won_d;
            lost_q      <= lost_d;
        end
    end

    // Read-side status registered alongside the RAM read data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_active_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            rd_active_q <= rd_active_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    board_row_ram u_ram (
        .clk_i   (clock),
        .rst_ni  (reset),
        .we_i    (pend_q),
        .waddr_i (pend_row_q),
        .wdata_i (pend_entry_q),
        .raddr_i (bus.rd_row),
        .rdata_o (ram_rdata)
    );

    // The shadow register doubles as the registered copy of the live row.
    assign rd_entry = rd_active_q ? prev_entry_q : ram_rdata;

    assign bus.rd_value01 = rd_entry[COLOR_LSB + 0*COLOR_W +: COLOR_W];
    assign bus.rd_value02 = rd_entry[COLOR_LSB + 1*COLOR_W +: COLOR_W];
    assign bus.rd_value03 = rd_entry[COLOR_LSB + 2*COLOR_W +: COLOR_W];
    assign bus.rd_value04 = rd_entry[COLOR_LSB + 3*COLOR_W +: COLOR_W];
    assign bus.rd_white   = rd_entry[WHITE_LSB +: PEG_W];
    assign bus.rd_black   = rd_entry[BLACK_LSB +: PEG_W];
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_active  = rd_active_q;
    assign bus.rows_done  = rows_done_q;
    assign bus.game_won   = won_q;
    assign bus.game_lost  = lost_q;

endmodule

// File: tb/tb_board_history.sv
// Bench for board_history: directed vector table, hand-written loss and
// reset sequences, then randomized play against a row-level reference model.
module tb_board_history;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    board_history_if bus ();

    board_history dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state: one stored row per slot as a plain integer code.
    int m_store [8];
    int m_valid [8];
    int m_count;
    int m_won;
    int m_lost;
    int m_last_row;
    int m_last_ent;
    int m_pend;
    int m_pend_row;
    int m_pend_ent;
    int e_ent;
    int e_valid;
    int e_active;

    typedef struct {
        int nr;
        int v1; int v2; int v3; int v4; int w; int b;
        int rd;
        int x_ent; int x_valid; int x_active; int x_rows; int x_won;
    } vec_t;

    vec_t tbl [13];

    function automatic int ent(input int v1, input int v2, input int v3, input int v4,
                               input int w, input int b);
        return v1 + 8*v2 + 64*v3 + 512*v4 + 4096*w + 32768*b;
    endfunction

    function automatic int live_ent();
        return ent(int'(bus.Value01), int'(bus.Value02), int'(bus.Value03),
                   int'(bus.Value04), int'(bus.WhitePegs), int'(bus.BlackPegs));
    endfunction

    function automatic int rd_ent();
        return ent(int'(bus.rd_value01), int'(bus.rd_value02), int'(bus.rd_value03),
                   int'(bus.rd_value04), int'(bus.rd_white), int'(bus.rd_black));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int nr, input int v1, input int v2, input int v3,
                         input int v4, input int w, input int b, input int rd);
        bus.nrOfRows  = 3'(nr);
        bus.Value01   = 3'(v1);
        bus.Value02   = 3'(v2);
        bus.Value03   = 3'(v3);
        bus.Value04   = 3'(v4);
        bus.WhitePegs = 3'(w);
        bus.BlackPegs = 3'(b);
        bus.rd_row    = 3'(rd);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_store[i] = 0;
            m_valid[i] = 0;
        end
        m_count    = 0;
        m_won      = 0;
        m_lost     = 0;
        m_last_row = 7;
        m_last_ent = 0;
        m_pend     = 0;
        m_pend_row = 0;
        m_pend_ent = 0;
        e_ent      = 0;
        e_valid    = 0;
        e_active   = 0;
    endtask

    // One clock edge of game play, from the inputs held across the edge.
    task automatic model_edge();
        int nr;
        int rr;
        int live;
        int over;
        nr   = int'(bus.nrOfRows);
        rr   = int'(bus.rd_row);
        live = live_ent();
        over = (m_won != 0 || m_lost != 0 ||
                (m_pend != 0 && ((m_pend_ent / 32768) == 4 || m_pend_row == 0))) ? 1 : 0;
        if (m_pend != 0) begin
            m_store[m_pend_row] = m_pend_ent;
            m_valid[m_pend_row] = 1;
            if (m_count < 8) m_count++;
            if ((m_pend_ent / 32768) == 4) m_won = 1;
            else if (m_pend_row == 0) m_lost = 1;
        end
        if (rr == nr && over == 0) begin
            e_active = 1;
            e_valid  = 0;
            e_ent    = live;
        end else begin
            e_active = 0;
            e_valid  = m_valid[rr];
            e_ent    = m_store[rr];
        end
        if (nr != m_last_row && over == 0) begin
            m_pend     = 1;
            m_pend_row = m_last_row;
            m_pend_ent = m_last_ent;
        end else begin
            m_pend = 0;
        end
        m_last_row = nr;
        m_last_ent = live;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_entry"},  rd_ent(),               e_ent);
        chk({tag, "_valid"},  int'(bus.rd_valid),     e_valid);
        chk({tag, "_active"}, int'(bus.rd_active),    e_active);
        chk({tag, "_rows"},   int'(bus.rows_done),    m_count);
        chk({tag, "_won"},    int'(bus.game_won),     m_won);
        chk({tag, "_lost"},   int'(bus.game_lost),    m_lost);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_model("rst");
        drive(7, 0, 0, 0, 0, 0, 0, 0);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        tbl[0]  = '{7, 2,6,5,1,2,1, 7, ent(2,6,5,1,2,1), 0, 1, 0, 0};
        tbl[1]  = '{6, 0,0,0,0,0,0, 7, 0,                0, 0, 0, 0};
        tbl[2]  = '{6, 0,0,0,0,0,0, 7, ent(2,6,5,1,2,1), 1, 0, 1, 0};
        tbl[3]  = '{6, 3,3,3,3,0,2, 6, ent(3,3,3,3,0,2), 0, 1, 1, 0};
        tbl[4]  = '{5, 0,0,0,0,0,0, 6, 0,                0, 0, 1, 0};
        tbl[5]  = '{5, 0,0,0,0,0,0, 6, ent(3,3,3,3,0,2), 1, 0, 2, 0};
        tbl[6]  = '{5, 4,4,4,4,0,4, 5, ent(4,4,4,4,0,4), 0, 1, 2, 0};
        tbl[7]  = '{4, 0,0,0,0,0,0, 5, 0,                0, 0, 2, 0};
        tbl[8]  = '{4, 0,0,0,0,0,0, 5, ent(4,4,4,4,0,4), 1, 0, 3, 1};
        tbl[9]  = '{4, 1,1,1,1,0,0, 4, 0,                0, 0, 3, 1};
        tbl[10] = '{3, 0,0,0,0,0,0, 4, 0,                0, 0, 3, 1};
        tbl[11] = '{3, 0,0,0,0,0,0, 4, 0,                0, 0, 3, 1};
        tbl[12] = '{3, 0,0,0,0,0,0, 7, ent(2,6,5,1,2,1), 1, 0, 3, 1};

        // Power-on reset.
        reset = 1'b0;
        drive(7, 1, 2, 3, 4, 0, 0, 7);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_model("por");
        reset = 1'b1;

        // Idle on row 7: live row is echoed, nothing is captured.
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_rows",   int'(bus.rows_done), 0);
            chk("hold_active", int'(bus.rd_active), 1);
            chk("hold_entry",  rd_ent(),            ent(1,2,3,4,0,0));
            chk("hold_valid",  int'(bus.rd_valid),  0);
        end

        // Directed capture / bypass / win vectors.
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].nr, tbl[i].v1, tbl[i].v2, tbl[i].v3, tbl[i].v4,
                  tbl[i].w, tbl[i].b, tbl[i].rd);
            step();
            chk($sformatf("tbl%0d_entry", i),  rd_ent(),            tbl[i].x_ent);
            chk($sformatf("tbl%0d_valid", i),  int'(bus.rd_valid),  tbl[i].x_valid);
            chk($sformatf("tbl%0d_active", i), int'(bus.rd_active), tbl[i].x_active);
            chk($sformatf("tbl%0d_rows", i),   int'(bus.rows_done), tbl[i].x_rows);
            chk($sformatf("tbl%0d_won", i),    int'(bus.game_won),  tbl[i].x_won);
        end

        // Eight losing rows through the 0 -> 7 wrap.
        async_reset();
        for (int r = 7; r >= 0; r--) begin
            drive(r, (r % 6) + 1, ((r + 1) % 6) + 1, ((r + 2) % 6) + 1, ((r + 3) % 6) + 1,
                  r % 5, r % 4, 0);
            step();
            drive((r + 7) % 8, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
        step();
        chk("loss_lost", int'(bus.game_lost), 1);
        chk("loss_won",  int'(bus.game_won),  0);
        chk("loss_rows", int'(bus.rows_done), 8);
        for (int k = 0; k < 8; k++) begin
            bus.rd_row = 3'(k);
            step();
            chk($sformatf("loss_valid%0d", k),  int'(bus.rd_valid),  1);
            chk($sformatf("loss_active%0d", k), int'(bus.rd_active), 0);
            chk($sformatf("loss_entry%0d", k),  rd_ent(),
                ent((k % 6) + 1, ((k + 1) % 6) + 1, ((k + 2) % 6) + 1, ((k + 3) % 6) + 1,
                    k % 5, k % 4));
        end
        bus.nrOfRows = 3'd2;
        step();
        step();
        chk("loss_frozen_rows", int'(bus.rows_done), 8);

        // Reset while a capture is pending: everything clears at once.
        async_reset();
        drive(7, 5, 4, 3, 2, 1, 3, 7);
        step();
        drive(6, 0, 0, 0, 0, 0, 0, 7);
        step();
        step();
        chk("pre_rst_valid", int'(bus.rd_valid), 1);
        chk("pre_rst_entry", rd_ent(),           ent(5,4,3,2,1,3));
        bus.nrOfRows = 3'd5;
        step();
        chk("pre_rst_rows",  int'(bus.rows_done), 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_entry",  rd_ent(),            0);
        chk("mid_rst_valid",  int'(bus.rd_valid),  0);
        chk("mid_rst_active", int'(bus.rd_active), 0);
        chk("mid_rst_rows",   int'(bus.rows_done), 0);
        model_reset();
        drive(7, 0, 0, 0, 0, 0, 0, 0);
        #1;
        reset = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            bus.rd_row = 3'(k);
            step();
            chk($sformatf("post_rst_valid%0d", k), int'(bus.rd_valid),  0);
            chk($sformatf("post_rst_rows%0d", k),  int'(bus.rows_done), 0);
        end

        // Randomized play against the reference model.
        async_reset();
        for (int c = 0; c < 1500; c++) begin
            if (((m_won != 0 || m_lost != 0) && $urandom_range(0, 7) == 0) ||
                $urandom_range(0, 299) == 0) begin
                async_reset();
            end
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 7) == 0) bus.nrOfRows = 3'($urandom_range(0, 7));
                else                           bus.nrOfRows = 3'(bus.nrOfRows - 3'd1);
                bus.Value01   = 3'd0;
                bus.Value02   = 3'd0;
                bus.Value03   = 3'd0;
                bus.Value04   = 3'd0;
                bus.WhitePegs = 3'd0;
                bus.BlackPegs = 3'd0;
            end else begin
                bus.Value01   = 3'($urandom_range(0, 6));
                bus.Value02   = 3'($urandom_range(0, 6));
                bus.Value03   = 3'($urandom_range(0, 6));
                bus.Value04   = 3'($urandom_range(0, 6));
                bus.WhitePegs = 3'($urandom_range(0, 4));
                bus.BlackPegs = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
            end
            bus.rd_row = 3'($urandom_range(0, 7));
            step();
            check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
